alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_exec_unit.sv | 186 ++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// RV32/64 integer ALU behind a valid/ready handshake: 1-cycle ops, or XLEN+1 cycles for M ops when ALU_EXEC_MDU_EN is defined.
// One op in flight; the result is held in DONE until out_ready, and in_ready stays low outside IDLE.
module alu_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);
  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              zero_q, zero_d;
  logic              accept;

  assign in_ready  = (state_q == IDLE) && !reset;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;

  // I-type (alu_op 11) has no subi, so funct7[5] only selects sra there
  function automatic logic [XLEN-1:0] alu_calc(input logic [1:0] op, input logic [2:0] f3,
                                               input logic f7_5, input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic [SHW-1:0] sh;
    sh = b[SHW-1:0];
    alu_calc = a + b;
    if (op == 2'b01) begin
      alu_calc = a - b;
    end else if (op[1]) begin
      case (f3)
        3'b000:  alu_calc = (!op[0] && f7_5) ? a - b : a + b;
        3'b001:  alu_calc = a << sh;
        3'b010:  alu_calc = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
        3'b011:  alu_calc = {{(XLEN-1){1'b0}}, a < b};
        3'b100:  alu_calc = a ^ b;
        3'b101:  alu_calc = f7_5 ? XLEN'($signed(a) >>> sh) : a >> sh;
        3'b110:  alu_calc = a | b;
        default: alu_calc = a & b;
      endcase
    end
  endfunction

`ifdef ALU_EXEC_MDU_EN
  logic [SHW-1:0]    cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d, acc_step, prod;
  logic [XLEN-1:0]   mb_q, mb_d, a_q, a_d, quo, rem, m_res;
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d, rneg_q, rneg_d;
  logic [XLEN:0]     trial, sum;
  logic              is_m, a_sgn, b_sgn;

  assign is_m  = (alu_op == 2'b10) && (funct7 == 7'b0000001);
  assign a_sgn = (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110}) && op_a[XLEN-1];
  assign b_sgn = (funct3 inside {3'b000, 3'b001, 3'b100, 3'b110}) && op_b[XLEN-1];

  // acc holds {hi, multiplier} for shift-add or {remainder, quotient} for restoring divide
  always_comb begin
    trial    = {acc_q[2*XLEN-1:XLEN-1]} - {1'b0, mb_q};
    sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mb_q} : '0);
    acc_step = {sum, acc_q[XLEN-1:1]};
    if (f3_q[2]) begin
      acc_step = trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                             : {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end
    prod = neg_q ? -acc_step : acc_step;
    quo  = (mb_q == '0) ? '1   : (neg_q  ? -acc_step[XLEN-1:0]      : acc_step[XLEN-1:0]);
    rem  = (mb_q == '0) ? a_q  : (rneg_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN]);
    case (f3_q)
      3'b000:          m_res = prod[XLEN-1:0];
      3'b100, 3'b101:  m_res = quo;
      3'b110, 3'b111:  m_res = rem;
      default:         m_res = prod[2*XLEN-1:XLEN];
    endcase
  end
`else
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};
`endif

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
`ifdef ALU_EXEC_MDU_EN
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    mb_d   = mb_q;
    a_d    = a_q;
    f3_d   = f3_q;
    neg_d  = neg_q;
    rneg_d = rneg_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef ALU_EXEC_MDU_EN
          if (is_m) begin
            cnt_d   = '0;
            acc_d   = {{XLEN{1'b0}}, a_sgn ? -op_a : op_a};
            mb_d    = b_sgn ? -op_b : op_b;
            a_d     = op_a;
            f3_d    = funct3;
            neg_d   = a_sgn ^ b_sgn;
            rneg_d  = a_sgn;
            state_d = BUSY;
          end else
`endif
          begin
            result_d    = alu_calc(alu_op, funct3, funct7[5], op_a, op_b);
            zero_d      = (result_d == '0);
            out_valid_d = 1'b1;
            state_d     = DONE;
          end
        end
      end
`ifdef ALU_EXEC_MDU_EN
      BUSY: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SHW'(XLEN-1)) begin
          result_d    = m_res;
          zero_d      = (m_res == '0);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
`endif
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
`ifdef ALU_EXEC_MDU_EN
      cnt_q  <= '0;
      acc_q  <= '0;
      mb_q   <= '0;
      a_q    <= '0;
      f3_q   <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
`ifdef ALU_EXEC_MDU_EN
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      mb_q   <= mb_d;
      a_q    <= a_d;
      f3_q   <= f3_d;
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
`endif
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit (XLEN=32): vector table, handshake/reset sequences, random ops vs. a reference model.
module tb_alu_exec_unit;
  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready, zero;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] op_a, op_b, result;
  int          errors = 0;
  int          checks = 0;

`ifdef ALU_EXEC_MDU_EN
  localparam bit MDU = 1'b1;
`else
  localparam bit MDU = 1'b0;
`endif

  always #5 clk = ~clk;

  alu_exec_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct3(funct3), .funct7(funct7), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero)
  );

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a, b, exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // RISC-V semantics computed with wide integer arithmetic
  function automatic logic [31:0] model(input logic [1:0] op, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [31:0] a,
                                        input logic [31:0] b);
    int sa, sb, sh;
    longint p, ua, ub;
    sa = a; sb = b; sh = int'(b % 32);
    ua = longint'(a); ub = longint'(b);
    if (MDU && op == 2'b10 && f7 == 7'd1) begin
      case (f3)
        3'd0: begin p = longint'(sa) * longint'(sb); return p[31:0]; end
        3'd1: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
        3'd2: begin p = longint'(sa) * ub; return p[63:32]; end
        3'd3: begin p = ua * ub; return p[63:32]; end
        3'd4: begin
          if (b == 0) return 32'hFFFF_FFFF;
          p = longint'(sa) / longint'(sb); return p[31:0];
        end
        3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
        3'd6: begin
          if (b == 0) return a;
          p = longint'(sa) % longint'(sb); return p[31:0];
        end
        default: return (b == 0) ? a : a % b;
      endcase
    end
    if (op == 2'b00) return a + b;
    if (op == 2'b01) return a - b;
    case (f3)
      3'd0: return (op == 2'b10 && f7[5]) ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return (sa < sb) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return f7[5] ? 32'(sa >>> sh) : a >> sh;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic [6:0] f7);
    return (MDU && op == 2'b10 && f7 == 7'd1) ? 33 : 1;
  endfunction

  // Starts and ends on a negedge with the unit idle
  task automatic run_op(input string name, input logic [1:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    int lat;
    @(negedge clk);
    check({name, ".in_ready"}, 32'(in_ready), 32'd1);
    alu_op = op; funct3 = f3; funct7 = f7; op_a = a; op_b = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    op_a = $urandom; op_b = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({name, ".latency"}, 32'(lat), 32'(exp_lat(op, f7)));
    check({name, ".result"}, result, exp);
    check({name, ".zero"}, 32'(zero), 32'(exp == 0));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, ".released"}, {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  function automatic vec_t mk(input string n, input logic [1:0] op, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp);
    vec_t v;
    v.name = n; v.op = op; v.f3 = f3; v.f7 = f7; v.a = a; v.b = b; v.exp = exp;
    return v;
  endfunction

  logic [31:0] pick [5];
  vec_t        vecs [$];
  int          seen;

  initial begin
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    alu_op = 2'b00; funct3 = 3'd0; funct7 = 7'd0; op_a = 32'd1; op_b = 32'd2;

    // Reset state, with in_valid held high throughout
    repeat (3) @(negedge clk);
    check("reset.in_ready", 32'(in_ready), 32'd0);
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.result", result, 32'd0);
    check("reset.zero", 32'(zero), 32'd1);
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("post_reset.idle", {30'd0, out_valid, in_ready}, 32'b01);

    vecs.push_back(mk("sub_r",      2'b10, 3'd0, 7'h20, 32'd5,          32'd7,          32'hFFFF_FFFE));
    vecs.push_back(mk("srai",       2'b11, 3'd5, 7'h20, 32'h8000_0000,  32'h0000_0024,  32'hF800_0000));
    vecs.push_back(mk("add_wrap",   2'b00, 3'd7, 7'h20, 32'hFFFF_FFFF,  32'd1,          32'd0));
    vecs.push_back(mk("sub_op01",   2'b01, 3'd0, 7'h00, 32'd3,          32'd5,          32'hFFFF_FFFE));
    vecs.push_back(mk("sll_mask",   2'b10, 3'd1, 7'h00, 32'd1,          32'h0000_0021,  32'd2));
    vecs.push_back(mk("slt_neg",    2'b10, 3'd2, 7'h00, 32'hFFFF_FFFF,  32'd1,          32'd1));
    vecs.push_back(mk("sltu_big",   2'b10, 3'd3, 7'h00, 32'hFFFF_FFFF,  32'd1,          32'd0));
    vecs.push_back(mk("xor",        2'b10, 3'd4, 7'h00, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0FF0_0FF0));
    vecs.push_back(mk("srl",        2'b10, 3'd5, 7'h00, 32'h8000_0000,  32'd4,          32'h0800_0000));
    vecs.push_back(mk("or",         2'b10, 3'd6, 7'h00, 32'h1234_0000,  32'h0000_5678,  32'h1234_5678));
    vecs.push_back(mk("and",        2'b10, 3'd7, 7'h00, 32'hFFFF_0000,  32'h0F0F_0F0F,  32'h0F0F_0000));
    vecs.push_back(mk("addi_f7",    2'b11, 3'd0, 7'h20, 32'd5,          32'd7,          32'd12));
    vecs.push_back(mk("sra_31",     2'b10, 3'd5, 7'h20, 32'h8000_0000,  32'd31,         32'hFFFF_FFFF));
    vecs.push_back(mk("slti_eq",    2'b11, 3'd2, 7'h00, 32'd5,          32'd5,          32'd0));
`ifdef ALU_EXEC_MDU_EN
    vecs.push_back(mk("mul",        2'b10, 3'd0, 7'h01, 32'd6,          32'd7,          32'd42));
    vecs.push_back(mk("div_ovf",    2'b10, 3'd4, 7'h01, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000));
    vecs.push_back(mk("divu_zero",  2'b10, 3'd5, 7'h01, 32'd1234,       32'd0,          32'hFFFF_FFFF));
    vecs.push_back(mk("rem_zero",   2'b10, 3'd6, 7'h01, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9));
    vecs.push_back(mk("mulhu_max",  2'b10, 3'd3, 7'h01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE));
    vecs.push_back(mk("div_neg",    2'b10, 3'd4, 7'h01, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD));
    vecs.push_back(mk("rem_neg",    2'b10, 3'd6, 7'h01, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF));
`else
    vecs.push_back(mk("f7_m_is_add", 2'b10, 3'd0, 7'h01, 32'd6,         32'd7,          32'd13));
`endif
    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].op, vecs[i].f3, vecs[i].f7,
                             vecs[i].a, vecs[i].b, vecs[i].exp);

    // Hold in DONE with out_ready low; new requests must be ignored
    @(negedge clk);
    alu_op = 2'b10; funct3 = 3'd0; funct7 = 7'h20; op_a = 32'd5; op_b = 32'd7; in_valid = 1'b1;
    @(negedge clk);
    check("hold.accept_lat1", 32'(out_valid), 32'd1);
    op_a = 32'd100; op_b = 32'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold.state", {29'd0, out_valid, in_ready, zero}, 32'b100);
      check("hold.result", result, 32'hFFFF_FFFE);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("hold.release", {30'd0, out_valid, in_ready}, 32'b01);
    @(negedge clk);
    check("hold.no_ghost", 32'(out_valid), 32'd0);

    // Reset while a result waits in DONE
    alu_op = 2'b00; op_a = 32'd9; op_b = 32'd9; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    check("rst_done.cleared", {29'd0, out_valid, in_ready, zero}, 32'b001);
    check("rst_done.result", result, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_done.idle", {30'd0, out_valid, in_ready}, 32'b01);

`ifdef ALU_EXEC_MDU_EN
    // Reset at BUSY cycle 10: the aborted product must never surface
    alu_op = 2'b10; funct3 = 3'd3; funct7 = 7'h01; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("busy.in_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("busy_rst.in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("busy_rst.no_out_valid", 32'(seen), 32'd0);
`endif

    // Random operations with boundary-biased operands
    pick[0] = 32'd0; pick[1] = 32'h8000_0000; pick[2] = 32'hFFFF_FFFF; pick[3] = 32'd1;
    for (int n = 0; n < 150; n++) begin
      logic [1:0]  r_op;
      logic [2:0]  r_f3;
      logic [6:0]  r_f7;
      logic [31:0] r_a, r_b;
      r_op = 2'($urandom_range(0, 3));
      r_f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       r_f7 = 7'h00;
        1:       r_f7 = 7'h20;
        2:       r_f7 = 7'h01;
        default: r_f7 = 7'($urandom);
      endcase
      pick[4] = $urandom; r_a = pick[$urandom_range(0, 4)];
      pick[4] = $urandom; r_b = pick[$urandom_range(0, 4)];
      if ($urandom_range(0, 1) == 1) r_a = $urandom;
      if ($urandom_range(0, 1) == 1) r_b = $urandom;
      run_op("rand", r_op, r_f3, r_f7, r_a, r_b, model(r_op, r_f3, r_f7, r_a, r_b));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
